// File: rtl/batalla_pkg.sv
// Shared types and constants for the battleship board placement logic.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package batalla_pkg;

  localparam int NUM_CASILLAS = 25;
  localparam int NUM_BARCOS   = 5;

  typedef logic [4:0] casilla_t;
  typedef logic [2:0] barco_id_t;
  typedef logic [2:0] coord_t;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    CHECK,
    COMMIT,
    DONE
  } estado_colocador_t;

endpackage

// File: rtl/verificador_casilla.sv
// Decides whether the cursor cell may take a new boat (free, and with ADYACENCIA_CHECK_EN no taken orthogonal neighbour).
// Latency: combinational.
// Backpressure: none; the caller samples valida while the cursor is stable.
module verificador_casilla
  import batalla_pkg::*;
#(
  parameter int FILAS    = 5,
  parameter int COLUMNAS = 5
) (
  input  logic [2:0]  fila,
  input  logic [2:0]  col,
  input  logic [31:0] ocupadas,
  output logic        valida
);

  casilla_t idx;

  assign idx = casilla_t'(int'(fila) * COLUMNAS + int'(col));

  // Reject taken cells; neighbours are looked at only inside the board (no wrap).
  always_comb begin
    valida = !ocupadas[idx];
`ifdef ADYACENCIA_CHECK_EN
    if (fila != '0 && ocupadas[casilla_t'(idx - casilla_t'(COLUMNAS))])
      valida = 1'b0;
    if (int'(fila) < FILAS - 1 && ocupadas[casilla_t'(idx + casilla_t'(COLUMNAS))])
      valida = 1'b0;
    if (col != '0 && ocupadas[casilla_t'(idx - 5'd1)])
      valida = 1'b0;
    if (int'(col) < COLUMNAS - 1 && ocupadas[casilla_t'(idx + 5'd1)])
      valida = 1'b0;
`endif
  end

endmodule

// File: rtl/colocador_barcos.sv
// Boat placement controller: moves a cursor over the board and writes each accepted boat to the register bank. Optional macro: ADYACENCIA_CHECK_EN.
// Latency: confirm at edge N -> enable/error during cycle N+2, ocupadas updated from N+3; move -> cursor next cycle.
// Backpressure: none; moves/confirms outside SELECT and start outside IDLE/DONE are dropped.
module colocador_barcos
  import batalla_pkg::*;
#(
  parameter int FILAS      = 5,
  parameter int COLUMNAS   = 5,
  parameter int NUM_BARCOS = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mover_arriba,
  input  logic        mover_abajo,
  input  logic        mover_izq,
  input  logic        mover_der,
  input  logic        confirmar,
  output logic        enable,
  output logic [2:0]  num_barco,
  output logic [4:0]  casilla_escogida,
  output logic [4:0]  cursor,
  output logic [31:0] ocupadas,
  output logic        error,
  output logic        listo
);

  estado_colocador_t estado;
  coord_t            fila;
  coord_t            col;
  coord_t            fila_sig;
  coord_t            col_sig;
  barco_id_t         contador;
  logic              valida;

  verificador_casilla #(
    .FILAS    (FILAS),
    .COLUMNAS (COLUMNAS)
  ) u_verificador (
    .fila     (fila),
    .col      (col),
    .ocupadas (ocupadas),
    .valida   (valida)
  );

  // Next cursor position: one move per cycle, priority arriba > abajo > izq > der, with wrap.
  always_comb begin
    fila_sig = fila;
    col_sig  = col;
    if (mover_arriba)
      fila_sig = (fila == '0) ? coord_t'(FILAS - 1) : coord_t'(fila - 3'd1);
    else if (mover_abajo)
      fila_sig = (fila == coord_t'(FILAS - 1)) ? '0 : coord_t'(fila + 3'd1);
    else if (mover_izq)
      col_sig = (col == '0) ? coord_t'(COLUMNAS - 1) : coord_t'(col - 3'd1);
    else if (mover_der)
      col_sig = (col == coord_t'(COLUMNAS - 1)) ? '0 : coord_t'(col + 3'd1);
  end

  // Placement FSM. The write strobe is registered on the CHECK->COMMIT edge so it is high during COMMIT.
  always_ff @(posedge clk) begin
    if (!rst) begin
      estado           <= IDLE;
      fila             <= '0;
      col              <= '0;
      cursor           <= '0;
      ocupadas         <= '0;
      contador         <= 3'd1;
      enable           <= 1'b0;
      error            <= 1'b0;
      listo            <= 1'b0;
      num_barco        <= '0;
      casilla_escogida <= '0;
    end else begin
      enable <= 1'b0;
      error  <= 1'b0;
      case (estado)
        IDLE, DONE: begin
          if (start) begin
            estado   <= SELECT;
            fila     <= '0;
            col      <= '0;
            cursor   <= '0;
            ocupadas <= '0;
            contador <= 3'd1;
            listo    <= 1'b0;
          end
        end
        SELECT: begin
          if (confirmar) begin
            estado <= CHECK;
          end else begin
            fila   <= fila_sig;
            col    <= col_sig;
            cursor <= casilla_t'(int'(fila_sig) * COLUMNAS + int'(col_sig));
          end
        end
        CHECK: begin
          if (valida) begin
            estado           <= COMMIT;
            enable           <= 1'b1;
            num_barco        <= contador;
            casilla_escogida <= cursor;
          end else begin
            estado <= SELECT;
            error  <= 1'b1;
          end
        end
        COMMIT: begin
          ocupadas[cursor] <= 1'b1;
          contador         <= contador + 3'd1;
          if (contador == barco_id_t'(NUM_BARCOS)) begin
            estado <= DONE;
            listo  <= 1'b1;
          end else begin
            estado <= SELECT;
          end
        end
        default: estado <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_colocador_barcos.sv
// Self-checking bench for colocador_barcos: directed scenarios plus random pulses against an event-based model.
// Latency: n/a.
// Backpressure: n/a.
module tb_colocador_barcos;

  localparam int F  = 5;
  localparam int C  = 5;
  localparam int NB = 5;

  logic        clk = 1'b0;
  logic        rst, start, arr, aba, izq, der, conf;
  logic        enable;
  logic [2:0]  num_barco;
  logic [4:0]  casilla_escogida;
  logic [4:0]  cursor;
  logic [31:0] ocupadas;
  logic        error;
  logic        listo;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  colocador_barcos #(.FILAS(F), .COLUMNAS(C), .NUM_BARCOS(NB)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .mover_arriba     (arr),
    .mover_abajo      (aba),
    .mover_izq        (izq),
    .mover_der        (der),
    .confirmar        (conf),
    .enable           (enable),
    .num_barco        (num_barco),
    .casilla_escogida (casilla_escogida),
    .cursor           (cursor),
    .ocupadas         (ocupadas),
    .error            (error),
    .listo            (listo)
  );

  // Model: board as a bit array, cursor as (row, col), and a confirm as a scheduled event.
  int        k = 0;
  int        mr, mc, mboat;
  bit [31:0] mocc;
  bit        en_ronda, pend, acc;
  int        out_edge, pcell, busy_until;
  bit        m_enable, m_error, m_listo;
  int        m_num, m_cas;

  int ev_num[$];
  int ev_cas[$];
  int n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit m_valida(input int r, input int c);
    bit ok;
    ok = !mocc[r*C + c];
`ifdef ADYACENCIA_CHECK_EN
    if (r > 0     && mocc[(r-1)*C + c]) ok = 0;
    if (r < F - 1 && mocc[(r+1)*C + c]) ok = 0;
    if (c > 0     && mocc[r*C + c - 1]) ok = 0;
    if (c < C - 1 && mocc[r*C + c + 1]) ok = 0;
`endif
    return ok;
  endfunction

  task automatic model_step();
    k++;
    m_enable = 0;
    m_error  = 0;
    if (!rst) begin
      mr = 0; mc = 0; mocc = 0; mboat = 1; en_ronda = 0; pend = 0;
      m_listo = 0; m_num = 0; m_cas = 0; busy_until = 0;
      return;
    end
    if (pend && k == out_edge) begin
      if (acc) begin
        m_enable = 1; m_num = mboat; m_cas = pcell;
      end else begin
        m_error = 1; pend = 0;
      end
    end else if (pend && acc && k == out_edge + 1) begin
      mocc[pcell] = 1'b1;
      mboat++;
      pend = 0;
      if (mboat > NB) begin
        en_ronda = 0; m_listo = 1;
      end
    end
    if (k < busy_until) return;
    if (!en_ronda) begin
      if (start) begin
        mr = 0; mc = 0; mocc = 0; mboat = 1; en_ronda = 1; m_listo = 0;
      end
    end else if (conf) begin
      pend = 1; acc = m_valida(mr, mc); pcell = mr*C + mc;
      out_edge = k + 1;
      busy_until = acc ? k + 3 : k + 2;
    end else if (arr) mr = (mr + F - 1) % F;
    else if (aba) mr = (mr + 1) % F;
    else if (izq) mc = (mc + C - 1) % C;
    else if (der) mc = (mc + 1) % C;
  endtask

  task automatic compare_all();
    chk("enable", {31'd0, enable}, {31'd0, m_enable});
    chk("error",  {31'd0, error},  {31'd0, m_error});
    chk("listo",  {31'd0, listo},  {31'd0, m_listo});
    chk("cursor", {27'd0, cursor}, 32'(mr*C + mc));
    chk("ocupadas", ocupadas, mocc);
    chk("num_barco", {29'd0, num_barco}, 32'(m_num));
    chk("casilla_escogida", {27'd0, casilla_escogida}, 32'(m_cas));
    if (enable) begin
      ev_num.push_back(int'(num_barco));
      ev_cas.push_back(int'(casilla_escogida));
    end
    if (error) n_err++;
  endtask

  task automatic clear_in();
    rst = 1; start = 0; arr = 0; aba = 0; izq = 0; der = 0; conf = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    clear_in();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic restart();
    ev_num.delete(); ev_cas.delete(); n_err = 0;
    rst = 0; tick();
    start = 1; tick();
  endtask

  initial begin
    clear_in();
    rst = 0;
    n_err = 0;
    ticks(2);
    chk("reset_cursor", {27'd0, cursor}, 32'd0);
    chk("reset_listo", {31'd0, listo}, 32'd0);

    // Five boats along row 0.
    restart();
    for (int b = 0; b < NB; b++) begin
      conf = 1; ticks(3);
`ifdef ADYACENCIA_CHECK_EN
      der = 1; tick(); der = 1; tick();
`else
      der = 1; tick();
`endif
    end
`ifndef ADYACENCIA_CHECK_EN
    chk("t1_nev", ev_num.size(), 32'd5);
    for (int b = 0; b < 5 && b < ev_num.size(); b++) begin
      chk("t1_num", 32'(ev_num[b]), 32'(b + 1));
      chk("t1_cas", 32'(ev_cas[b]), 32'(b));
    end
    chk("t1_listo", {31'd0, listo}, 32'd1);
    chk("t1_ocupadas", ocupadas, 32'h1F);
    chk("t1_model_occ", mocc, 32'h1F);
`endif

    // Wrap-around moves from (0,0).
    restart();
    arr = 1; tick(); chk("t2_up", {27'd0, cursor}, 32'd20);
    izq = 1; tick(); chk("t2_left", {27'd0, cursor}, 32'd24);
    der = 1; tick(); chk("t2_right", {27'd0, cursor}, 32'd20);

    // Same cell confirmed twice.
    restart();
    conf = 1; ticks(3);
    conf = 1; ticks(3);
    der = 1; tick(); der = 1; tick();
    conf = 1; ticks(3);
    chk("t3_nev", ev_num.size(), 32'd2);
    chk("t3_err", 32'(n_err), 32'd1);
    if (ev_num.size() == 2) begin
      chk("t3_b1", 32'(ev_num[0] * 100 + ev_cas[0]), 32'd100);
      chk("t3_b2", 32'(ev_num[1] * 100 + ev_cas[1]), 32'd202);
    end

`ifdef ADYACENCIA_CHECK_EN
    // Adjacent cell rejected, one further along accepted.
    restart();
    aba = 1; tick(); aba = 1; tick(); der = 1; tick(); der = 1; tick();
    conf = 1; ticks(3);
    der = 1; tick();
    conf = 1; ticks(2);
    der = 1; tick();
    conf = 1; ticks(3);
    chk("t4_err", 32'(n_err), 32'd1);
    chk("t4_nev", ev_num.size(), 32'd2);
    if (ev_num.size() == 2) begin
      chk("t4_b1", 32'(ev_num[0] * 100 + ev_cas[0]), 32'd112);
      chk("t4_b2", 32'(ev_num[1] * 100 + ev_cas[1]), 32'd214);
    end
`endif

    // Simultaneous up+right from cell 6.
    restart();
    aba = 1; tick(); der = 1; tick();
    chk("t5_at6", {27'd0, cursor}, 32'd6);
    arr = 1; der = 1; tick();
    chk("t5_cursor", {27'd0, cursor}, 32'd1);

    // Reset during the COMMIT of boat 3.
    restart();
    conf = 1; ticks(3);
    der = 1; tick(); der = 1; tick();
    conf = 1; ticks(3);
    der = 1; tick(); der = 1; tick();
    conf = 1; ticks(2);
    chk("t6_commit3", {31'd0, enable}, 32'd1);
    rst = 0; tick();
    chk("t6_enable", {31'd0, enable}, 32'd0);
    chk("t6_ocupadas", ocupadas, 32'd0);
    start = 1; tick();
    conf = 1; ticks(2);
    chk("t6_enable_again", {31'd0, enable}, 32'd1);
    chk("t6_num", {29'd0, num_barco}, 32'd1);

    // Random pulses.
    for (int i = 0; i < 4000; i++) begin
      rst   = ($urandom_range(0, 199) != 0);
      start = ($urandom_range(0, 19) == 0);
      arr   = ($urandom_range(0, 5) == 0);
      aba   = ($urandom_range(0, 5) == 0);
      izq   = ($urandom_range(0, 5) == 0);
      der   = ($urandom_range(0, 5) == 0);
      conf  = ($urandom_range(0, 4) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
